// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver that samples each bit at its centre and hands bytes to a
// one-entry valid/ready buffer, with sticky framing-error and overrun flags.
module uart_rx_stream #(
    parameter int CLK_HZ  = 100800000,
    parameter int SCLK_HZ = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       framing_error,
    output logic       overrun,
    input  logic       clear_status
);
    localparam int DIV  = CLK_HZ / SCLK_HZ;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t          state_q;
    logic [1:0]      sync_q;
    logic [2:0]      settle_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            done_q;
    logic [7:0]      dout_q;
    logic            valid_q;
    logic            fe_q;
    logic            ov_q;
    logic            rxd_s;
    assign rxd_s         = sync_q[1];
    assign dout          = dout_q;
    assign dout_valid    = valid_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            settle_q <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            done_q   <= 1'b0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], uart_rxd};
            settle_q <= {settle_q[1:0], 1'b1};
            done_q   <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
            if (clear_status) begin
                fe_q <= 1'b0;
                ov_q <= 1'b0;
            end
            case (state_q)
                // The first low seen once the synchronizer has flushed is a line that was
                // already low across reset, so it is parked in BREAK rather than started.
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxd_s) state_q <= settle_q[2] ? START : BREAK;
                end
                START: if (cnt_q == HALF_END) begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= rxd_s ? IDLE : DATA;
                end
                DATA: if (cnt_q == BIT_END) begin
                    cnt_q   <= '0;
                    shift_q <= {rxd_s, shift_q[7:1]};
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == 3'd7) state_q <= STOP;
                end
                STOP: if (cnt_q == BIT_END) begin
                    cnt_q   <= '0;
                    done_q  <= rxd_s;
                    fe_q    <= fe_q | !rxd_s;
                    state_q <= rxd_s ? IDLE : BREAK;
                end
                BREAK: begin
                    cnt_q <= '0;
                    if (rxd_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (done_q && (!valid_q || dout_ready)) begin
                dout_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (done_q) begin
                ov_q <= 1'b1;
            end else if (valid_q && dout_ready) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream: drives serial frames into uart_rx_stream and scores delivered bytes
// against a queue of expected bytes filled as frames are sent.
module tb_uart_rx_stream;
    localparam int SCLK_HZ = 115200;
    localparam int CLK_HZ  = SCLK_HZ * 64;
    localparam int DIV     = 64;
    localparam int HALF    = DIV / 2;
    localparam int LAT     = 2 + HALF + 9 * DIV + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       dout_ready = 1'b0;
    logic       clear_status = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       framing_error;
    logic       overrun;

    int         checks = 0;
    int         errors = 0;
    int         tick_n = 0;
    int         pop_tick = -1;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_stream #(.CLK_HZ(CLK_HZ), .SCLK_HZ(SCLK_HZ)) dut (
        .clk(clk),
        .reset(reset),
        .uart_rxd(uart_rxd),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .framing_error(framing_error),
        .overrun(overrun),
        .clear_status(clear_status)
    );

    // One clock: score any handshake at the negedge, then return just after the next posedge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (dout_valid && dout_ready) begin
            checks++;
            pop_tick = tick_n;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %02h, no byte expected", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL byte_value: got %02h, expected %02h", dout, e);
                end
            end
        end
        @(posedge clk);
        #1;
        tick_n++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Sends the first nbits bit-periods of a frame (start, 8 data LSB first, stop), then idles high.
    task automatic send(input logic [7:0] b, input logic stop, input int nbits, input logic expect_byte);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        if (expect_byte) exp_q.push_back(b);
        tick_n = 0;
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = frame[i];
            ticks(DIV);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * DIV) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d bytes still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ticks(4);
        checks += 4;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %02h, expected 00", dout); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", dout_valid); end
        if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b, expected 0", framing_error); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b, expected 0", overrun); end
        reset = 1'b0;
        ticks(2 * DIV);
    endtask

    task automatic test_basic();
        dout_ready = 1'b1;
        pop_tick = -1;
        send(8'h55, 1'b1, 10, 1'b1);
        drain();
        // The line falls just after a posedge, so the first sampling edge is one tick later.
        checks += 3;
        if (pop_tick != LAT + 1) begin errors++; $display("FAIL latency: got %0d, expected %0d", pop_tick, LAT + 1); end
        if (framing_error !== 1'b0) begin errors++; $display("FAIL basic_fe: got %b, expected 0", framing_error); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL basic_ov: got %b, expected 0", overrun); end
        ticks(DIV);
    endtask

    task automatic test_hold();
        int bad;
        dout_ready = 1'b0;
        send(8'hA3, 1'b1, 10, 1'b1);
        bad = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (dout_valid !== 1'b1 || dout !== 8'hA3) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles, expected 0", bad); end
        dout_ready = 1'b1;
        tick();
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL hold_accept: %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL hold_valid_drop: got %b, expected 0", dout_valid); end
        ticks(DIV);
    endtask

    task automatic test_glitch();
        dout_ready = 1'b1;
        uart_rxd = 1'b0;
        ticks(15);
        uart_rxd = 1'b1;
        ticks(2 * DIV);
        checks += 2;
        if (framing_error !== 1'b0) begin errors++; $display("FAIL glitch_fe: got %b, expected 0", framing_error); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL glitch_ov: got %b, expected 0", overrun); end
        send(8'h5A, 1'b1, 10, 1'b1);
        drain();
        ticks(DIV);
    endtask

    task automatic test_framing();
        dout_ready = 1'b1;
        send(8'h3C, 1'b0, 10, 1'b0);
        ticks(DIV);
        checks += 2;
        if (framing_error !== 1'b1) begin errors++; $display("FAIL framing_set: got %b, expected 1", framing_error); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL framing_nobyte: got %b, expected 0", dout_valid); end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++;
        if (framing_error !== 1'b0) begin errors++; $display("FAIL framing_clear: got %b, expected 0", framing_error); end
        ticks(DIV);
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b0;
        send(8'h11, 1'b1, 10, 1'b1);
        send(8'h22, 1'b1, 10, 1'b0);
        send(8'h33, 1'b1, 10, 1'b0);
        ticks(DIV);
        checks += 3;
        if (dout !== 8'h11) begin errors++; $display("FAIL overrun_dout: got %02h, expected 11", dout); end
        if (dout_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b, expected 1", dout_valid); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, expected 1", overrun); end
        dout_ready = 1'b1;
        tick();
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL overrun_accept: %0d pending, expected 0", exp_q.size()); exp_q.delete(); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL overrun_drop: got %b, expected 0", dout_valid); end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b, expected 0", overrun); end
        ticks(DIV);
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        send(8'h77, 1'b1, 10, 1'b0);
        ticks(DIV);
        send(8'hF0, 1'b1, 5, 1'b0);
        ticks(HALF);
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        checks += 2;
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, expected 0", dout_valid); end
        if (dout !== 8'h00) begin errors++; $display("FAIL midreset_dout: got %02h, expected 00", dout); end
        ticks(5 * DIV);
        dout_ready = 1'b1;
        send(8'h0F, 1'b1, 10, 1'b1);
        drain();
        checks += 2;
        if (framing_error !== 1'b0) begin errors++; $display("FAIL midreset_fe: got %b, expected 0", framing_error); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL midreset_ov: got %b, expected 0", overrun); end
        ticks(DIV);
    endtask

    task automatic test_reset_low();
        dout_ready = 1'b1;
        uart_rxd = 1'b0;
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(3 * DIV);
        uart_rxd = 1'b1;
        ticks(2 * DIV);
        checks += 2;
        if (framing_error !== 1'b0) begin errors++; $display("FAIL lowreset_fe: got %b, expected 0", framing_error); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL lowreset_valid: got %b, expected 0", dout_valid); end
        send(8'h81, 1'b1, 10, 1'b1);
        drain();
        ticks(DIV);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_reset_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
